// File: rtl/vga_pattern_mixer_if.sv
// Pixel/colour bus between the colour register bank, the pattern mixer and the VGA output stage.
// The master drives colours, layout controls and coordinates. The slave returns the pixel stream.
interface vga_pattern_mixer_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH*24-1:0] ch_data;
  logic                 ch_load;
  logic [1:0]           mode;
  logic                 blink_en;
  logic [3:0]           resolution;
  logic                 px_valid;
  logic [10:0]          px_h;
  logic [10:0]          px_v;
  logic                 px_out_valid;
  logic [23:0]          px_24bit_data;
  logic [11:0]          px_12bit_data;
  logic                 load_pending;

  modport master (
    output ch_data, ch_load, mode, blink_en, resolution, px_valid, px_h, px_v,
    input  px_out_valid, px_24bit_data, px_12bit_data, load_pending
  );

  modport slave (
    input  ch_data, ch_load, mode, blink_en, resolution, px_valid, px_h, px_v,
    output px_out_valid, px_24bit_data, px_12bit_data, load_pending
  );
endinterface

// File: rtl/vga_pattern_mixer.sv
// Maps pixel coordinates to one of NUM_CH channel colours (bars, grid or checker layout).
// Colours and layout are double-buffered and commit at frame start. Output follows 2 cycles later.
module vga_pattern_mixer #(
  parameter int NUM_CH     = 4,
  parameter int CELL_LOG2  = 5,
  parameter int BLINK_LOG2 = 5
) (
  input  logic               clk,
  input  logic               rst,
  vga_pattern_mixer_if.slave bus
);
  localparam int CH_W = NUM_CH * 24;

  logic [CH_W-1:0]       shadow_ch;
  logic [CH_W-1:0]       active_ch;
  logic [1:0]            shadow_mode;
  logic [1:0]            active_mode;
  logic [3:0]            active_res;
  logic [BLINK_LOG2-1:0] frame_cnt;
  logic                  load_pending;
  logic                  frame_start;
  logic [10:0]           h_size;
  logic [10:0]           v_size;
  logic [2:0]            idx_next;
  logic                  act_next;
  logic [2:0]            idx_p1;
  logic                  act_p1;
  logic                  vld_p1;
  logic [23:0]           rgb_p2;
  logic                  vld_p2;

  // Returns {H, V} of the active area. Unknown codes fall back to 640x480.
  function automatic logic [21:0] res_size(input logic [3:0] res);
    case (res)
      4'd1:    return {11'd800, 11'd600};
      4'd2:    return {11'd1024, 11'd768};
      4'd3:    return {11'd1280, 11'd1024};
      default: return {11'd640, 11'd480};
    endcase
  endfunction

  function automatic logic [11:0] to_rgb444(input logic [23:0] c);
    return {c[23:20], c[15:12], c[7:4]};
  endfunction

  function automatic logic [23:0] pick_colour(input logic [CH_W-1:0] chs, input logic [2:0] idx,
                                              input logic act, input logic inv);
    logic [23:0] c;
    c = 24'h000000;
    if (act && int'(idx) < NUM_CH) c = chs[idx*24 +: 24];
    if (act && inv) c = ~c;
    return c;
  endfunction

  assign frame_start      = bus.px_valid && (bus.px_h == 11'd0) && (bus.px_v == 11'd0);
  assign {h_size, v_size} = res_size(active_res);

  // Bar index counts the boundaries k*size/NUM_CH already crossed, so no divider is needed.
  always_comb begin
    idx_next = 3'd0;
    case (active_mode)
      2'd0: begin
        for (int k = 1; k < NUM_CH; k++)
          if (({21'd0, bus.px_h} * NUM_CH) >= (k * {21'd0, h_size})) idx_next = idx_next + 3'd1;
      end
      2'd1: begin
        for (int k = 1; k < NUM_CH; k++)
          if (({21'd0, bus.px_v} * NUM_CH) >= (k * {21'd0, v_size})) idx_next = idx_next + 3'd1;
      end
      2'd2:    idx_next = {1'b0, bus.px_v >= (v_size >> 1), bus.px_h >= (h_size >> 1)};
      default: idx_next = {2'b00, bus.px_h[CELL_LOG2] ^ bus.px_v[CELL_LOG2]};
    endcase
  end

  assign act_next = (bus.px_h < h_size) && (bus.px_v < v_size);

  // A load in the frame-start cycle lands in the shadow after the commit, so it stays pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_ch    <= '0;
      active_ch    <= '0;
      shadow_mode  <= 2'd0;
      active_mode  <= 2'd0;
      active_res   <= 4'd0;
      frame_cnt    <= '0;
      load_pending <= 1'b0;
    end else begin
      shadow_mode <= bus.mode;
      if (bus.ch_load) shadow_ch <= bus.ch_data;
      if (frame_start) begin
        active_ch   <= shadow_ch;
        active_mode <= shadow_mode;
        active_res  <= bus.resolution;
        frame_cnt   <= frame_cnt + 1'b1;
      end
      if (bus.ch_load)      load_pending <= 1'b1;
      else if (frame_start) load_pending <= 1'b0;
    end
  end

  // Stage p1: channel index and active-area flag. Stage p2: final colour.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
      idx_p1 <= 3'd0;
      act_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      rgb_p2 <= 24'h000000;
    end else begin
      vld_p1 <= bus.px_valid;
      if (bus.px_valid) begin
        idx_p1 <= idx_next;
        act_p1 <= act_next;
      end
      vld_p2 <= vld_p1;
      if (vld_p1) rgb_p2 <= pick_colour(active_ch, idx_p1, act_p1, bus.blink_en && frame_cnt[BLINK_LOG2-1]);
    end
  end

  assign bus.px_out_valid  = vld_p2;
  assign bus.px_24bit_data = rgb_p2;
  assign bus.px_12bit_data = to_rgb444(rgb_p2);
  assign bus.load_pending  = load_pending;
endmodule
